// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: opcodes, ALU codes, FSM states, mux selects.
// The ALU imports alu_ctrl_e from here as well.
package mc_pkg;

    localparam int DATA_W = 24;
    localparam int OPC_W  = 4;
    localparam int CTRL_W = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_BZ   = 4'h9,
        OP_BN   = 4'hA,
        OP_JMP  = 4'hB,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_PASS_B = 4'd5
    } alu_ctrl_e;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ALU_WB = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WB = 4'd7,
        S_MEM_WR = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11
    } state_e;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_ONE  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_IMM    = 2'd2;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    endfunction

    function automatic alu_ctrl_e exec_alu(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_flag_reg.sv
// 3-bit {c,n,z} flag register: loads on we, cleared synchronously by rst_n low.
module mc_flag_reg
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [2:0] d,
    output logic [2:0] q
);

    logic [2:0] flags_q;
    logic [2:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (we) begin
            flags_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign q = flags_q;

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the 24-bit multicycle computer; outputs decode from state and opcode.
// ILLEGAL_TRAP_EN: when defined, opcodes C/D/E trap to HALT and set sticky illegal_op.
//
// state  | meaning
// IDLE   | after reset, all outputs low
// FETCH  | IR <= mem[PC], PC <= PC+1
// DECODE | ALUOut <= branch target, dispatch on opcode
// EXEC   | R-type / ADDI operation, flags captured
// ALU_WB | rd <= ALUOut
// ADDR   | ALUOut <= rs + sext(imm)
// MEM_RD | MDR <= mem[ALUOut]
// MEM_WB | rd <= MDR
// MEM_WR | mem[ALUOut] <= rd
// BRANCH | conditional PC <= ALUOut
// JUMP   | PC <= zext(imm)
// HALT   | stopped until reset
module multicycle_control_unit
    import mc_pkg::*;
#(
    parameter int DATA_W = mc_pkg::DATA_W,
    parameter int OPC_W  = mc_pkg::OPC_W,
    parameter int CTRL_W = mc_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] instr,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic              alu_cout,
    output logic              pc_write,
    output logic              ir_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              i_or_d,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [CTRL_W-1:0] alu_control,
    output logic [1:0]        pc_src,
    output logic [2:0]        flags,
    output logic              halted,
    output logic              illegal_op
);

    state_e     state_q, state_d;
    logic       halted_q, halted_d;
    logic [3:0] opc;
    logic       flag_we;
    logic       unused_instr;

    assign opc          = 4'(instr[DATA_W-1 -: OPC_W]);
    assign unused_instr = ^instr[DATA_W-OPC_W-1:0];

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d = state_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opc)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_ADDR;
                    OP_BZ, OP_BN:  state_d = S_BRANCH;
                    OP_JMP:        state_d = S_JUMP;
                    OP_HALT:       state_d = S_HALT;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        if (is_illegal(opc)) begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end else begin
                            state_d = S_FETCH;
                        end
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_EXEC:   state_d = S_ALU_WB;
            S_ALU_WB: state_d = S_FETCH;
            S_ADDR:   state_d = (opc == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = S_MEM_WB;
            S_MEM_WB: state_d = S_FETCH;
            S_MEM_WR: state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            halted_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Branch decision uses the flags held from the last EXEC, not the live ALU flags.
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        i_or_d      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_control = CTRL_W'(ALU_ADD);
        pc_src      = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_ONE;
            end
            S_DECODE: alu_src_b = SRCB_IMM;
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = (opc == OP_ADDI) ? SRCB_IMM : SRCB_REG;
                alu_control = CTRL_W'(exec_alu(opc));
            end
            S_ALU_WB: reg_write = 1'b1;
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                pc_src   = PCSRC_ALUOUT;
                pc_write = ((opc == OP_BZ) && flags[0]) || ((opc == OP_BN) && flags[1]);
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_IMM;
            end
            default: ;
        endcase
    end

    assign flag_we = (state_q == S_EXEC);

    mc_flag_reg u_flags (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (flag_we),
        .d     ({alu_cout, alu_n, alu_z}),
        .q     (flags)
    );

    assign halted = halted_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit; control outputs are packed into one word per cycle.
// Honours ILLEGAL_TRAP_EN the same way the design does.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] instr = 24'h0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_cout = 1'b0;
    logic        pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_control;
    logic [2:0]  flags;
    logic        halted, illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc_write,ir_write,mem_read,mem_write,i_or_d,reg_write,mem_to_reg,alu_src_a,alu_src_b,alu_control,pc_src}
    logic [15:0] ctrl;
    assign ctrl = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, mem_to_reg,
                   alu_src_a, alu_src_b, alu_control, pc_src};

    localparam logic [15:0] C_IDLE   = 16'h0000;
    localparam logic [15:0] C_FETCH  = 16'hE040;
    localparam logic [15:0] C_DECODE = 16'h0080;
    localparam logic [15:0] C_ALU_WB = 16'h0400;
    localparam logic [15:0] C_ADDR   = 16'h0180;
    localparam logic [15:0] C_MEM_RD = 16'h2800;
    localparam logic [15:0] C_MEM_WB = 16'h0600;
    localparam logic [15:0] C_MEM_WR = 16'h1800;
    localparam logic [15:0] C_BR_T   = 16'h8001;
    localparam logic [15:0] C_BR_NT  = 16'h0001;
    localparam logic [15:0] C_JUMP   = 16'h8002;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .alu_z(alu_z), .alu_n(alu_n), .alu_cout(alu_cout),
        .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .i_or_d(i_or_d), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
        .flags(flags), .halted(halted), .illegal_op(illegal_op)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (ctrl !== C_IDLE || flags !== 3'b000 || halted !== 1'b0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ctrl=%h flags=%b halted=%b illegal=%b, expected ctrl=%h flags=000 halted=0 illegal=0",
                     ctrl, flags, halted, illegal_op, C_IDLE);
        end
        rst_n = 1'b1;
    endtask

    // Entered sampling IDLE (cycle 1 after reset release); reg_write only in cycle 5.
    task automatic test_add();
        logic [15:0] exp [5];
        exp = '{C_IDLE, C_FETCH, C_DECODE, 16'h0100, C_ALU_WB};
        instr = 24'h112000;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (ctrl !== exp[i]) begin
                n_fail++;
                $display("FAIL add_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, exp[i]);
            end
        end
        tick();
    endtask

    // Each R-type/ADDI opcode checked in EXEC; every task below enters sampling FETCH.
    task automatic test_alu_ops();
        logic [23:0] ins  [6];
        logic [15:0] exec [6];
        ins  = '{24'h112000, 24'h212000, 24'h312000, 24'h412000, 24'h512000, 24'h612345};
        exec = '{16'h0100,   16'h0104,   16'h0108,   16'h010C,   16'h0110,   16'h0180};
        for (int k = 0; k < 6; k++) begin
            logic [15:0] exp [4];
            exp = '{C_FETCH, C_DECODE, exec[k], C_ALU_WB};
            instr = ins[k];
            for (int i = 0; i < 4; i++) begin
                if (i > 0) tick();
                n_checks++;
                if (ctrl !== exp[i]) begin
                    n_fail++;
                    $display("FAIL aluop_%h_cycle%0d: ctrl=%h expected %h", ins[k], i + 1, ctrl, exp[i]);
                end
            end
            tick();
        end
    endtask

    // SUB captures {c,n,z} in EXEC; branch then sees opposite live flags that must be ignored.
    task automatic test_sub_branch(input logic c, input logic n, input logic z,
                                   input logic [23:0] br, input logic [15:0] exp_br,
                                   input logic [2:0] exp_flags);
        logic [15:0] exp [7];
        exp = '{C_FETCH, C_DECODE, 16'h0104, C_ALU_WB, C_FETCH, C_DECODE, exp_br};
        alu_cout = c; alu_n = n; alu_z = z;
        instr = 24'h212000;
        for (int i = 0; i < 7; i++) begin
            if (i > 0) tick();
            if (i == 4) begin
                instr = br;
                alu_cout = ~c; alu_n = ~n; alu_z = ~z;
            end
            n_checks++;
            if (ctrl !== exp[i]) begin
                n_fail++;
                $display("FAIL subbr_%h_cycle%0d: ctrl=%h expected %h", br, i + 1, ctrl, exp[i]);
            end
            if (i == 3 || i == 6) begin
                n_checks++;
                if (flags !== exp_flags) begin
                    n_fail++;
                    $display("FAIL subbr_%h_flags_cycle%0d: flags=%b expected %b", br, i + 1, flags, exp_flags);
                end
            end
        end
        tick();
        alu_cout = 1'b0; alu_n = 1'b0; alu_z = 1'b0;
    endtask

    task automatic test_lw_sw(input logic [2:0] held_flags);
        logic [15:0] lw [5];
        logic [15:0] sw [5];
        lw = '{C_FETCH, C_DECODE, C_ADDR, C_MEM_RD, C_MEM_WB};
        sw = '{C_FETCH, C_DECODE, C_ADDR, C_MEM_WR, C_FETCH};
        alu_cout = ~held_flags[2]; alu_n = ~held_flags[1]; alu_z = ~held_flags[0];
        instr = 24'h700010;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (ctrl !== lw[i]) begin
                n_fail++;
                $display("FAIL lw_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, lw[i]);
            end
        end
        tick();
        instr = 24'h800020;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (ctrl !== sw[i]) begin
                n_fail++;
                $display("FAIL sw_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, sw[i]);
            end
        end
        n_checks++;
        if (flags !== held_flags) begin
            n_fail++;
            $display("FAIL lwsw_flags_held: flags=%b expected %b", flags, held_flags);
        end
        alu_cout = 1'b0; alu_n = 1'b0; alu_z = 1'b0;
    endtask

    task automatic test_jmp_nop();
        logic [15:0] exp [6];
        exp = '{C_FETCH, C_DECODE, C_JUMP, C_FETCH, C_DECODE, C_FETCH};
        instr = 24'hB00055;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            if (i == 3) instr = 24'h000000;
            n_checks++;
            if (ctrl !== exp[i]) begin
                n_fail++;
                $display("FAIL jmp_nop_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, exp[i]);
            end
        end
    endtask

    // Reset asserted while in MEM_WR; flags are nonzero going in.
    task automatic test_reset_mid(input logic [2:0] flags_before);
        logic [15:0] exp [4];
        exp = '{C_FETCH, C_DECODE, C_ADDR, C_MEM_WR};
        instr = 24'h800020;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (ctrl !== exp[i]) begin
                n_fail++;
                $display("FAIL rstmid_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, exp[i]);
            end
        end
        n_checks++;
        if (flags !== flags_before) begin
            n_fail++;
            $display("FAIL rstmid_flags_before: flags=%b expected %b", flags, flags_before);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (ctrl !== C_IDLE || flags !== 3'b000) begin
            n_fail++;
            $display("FAIL rstmid_after: ctrl=%h flags=%b expected ctrl=%h flags=000", ctrl, flags, C_IDLE);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (ctrl !== C_FETCH) begin
            n_fail++;
            $display("FAIL rstmid_refetch: ctrl=%h expected %h", ctrl, C_FETCH);
        end
    endtask

    task automatic test_halt();
        logic [15:0] exp [2];
        exp = '{C_FETCH, C_DECODE};
        instr = 24'hF00000;
        for (int i = 0; i < 2; i++) begin
            if (i > 0) tick();
            n_checks++;
            if (ctrl !== exp[i]) begin
                n_fail++;
                $display("FAIL halt_cycle%0d: ctrl=%h expected %h", i + 1, ctrl, exp[i]);
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 1) instr = 24'h112000;
            n_checks++;
            if (ctrl !== C_IDLE || halted !== 1'b1) begin
                n_fail++;
                $display("FAIL halt_hold%0d: ctrl=%h halted=%b expected ctrl=%h halted=1", i, ctrl, halted, C_IDLE);
            end
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (halted !== 1'b0 || ctrl !== C_IDLE) begin
            n_fail++;
            $display("FAIL halt_release: halted=%b ctrl=%h expected halted=0 ctrl=%h", halted, ctrl, C_IDLE);
        end
        tick();
    endtask

    task automatic test_illegal();
        instr = 24'hC00000;
        n_checks++;
        if (ctrl !== C_FETCH) begin
            n_fail++;
            $display("FAIL illegal_fetch: ctrl=%h expected %h", ctrl, C_FETCH);
        end
        tick();
        n_checks++;
        if (ctrl !== C_DECODE) begin
            n_fail++;
            $display("FAIL illegal_decode: ctrl=%h expected %h", ctrl, C_DECODE);
        end
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ctrl !== C_IDLE || halted !== 1'b1 || illegal_op !== 1'b1) begin
                n_fail++;
                $display("FAIL illegal_trap%0d: ctrl=%h halted=%b illegal=%b expected ctrl=%h halted=1 illegal=1",
                         i, ctrl, halted, illegal_op, C_IDLE);
            end
            instr = 24'h000000;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (illegal_op !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_clear: illegal=%b halted=%b expected 0 0", illegal_op, halted);
        end
`else
        n_checks++;
        if (ctrl !== C_FETCH || halted !== 1'b0 || illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_as_nop: ctrl=%h halted=%b illegal=%b expected ctrl=%h halted=0 illegal=0",
                     ctrl, halted, illegal_op, C_FETCH);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_sub_branch(1'b0, 1'b0, 1'b1, 24'h900004, C_BR_T,  3'b001);
        test_sub_branch(1'b0, 1'b0, 1'b0, 24'h900004, C_BR_NT, 3'b000);
        test_sub_branch(1'b1, 1'b1, 1'b0, 24'hA00004, C_BR_T,  3'b110);
        test_sub_branch(1'b1, 1'b1, 1'b0, 24'h900004, C_BR_NT, 3'b110);
        test_lw_sw(3'b110);
        test_jmp_nop();
        test_reset_mid(3'b110);
        test_halt();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Moore-style FSM that sequences the multicycle computer: instruction fetch, decode, execute, memory access and writeback.
- Sits directly upstream of the 24-bit ALU. Drives its 4-bit alu_control and the datapath muxes feeding A_in/B_in.
- Consumes the ALU Z/N/cout outputs into a registered flag set used by conditional branches.
- Instruction format is 24 bits: [23:20] opcode, [19:16] rd, [15:12] rs, [11:0] imm12.

Parameters:
- DATA_W, 24, datapath/instruction width.
- OPC_W, 4, opcode field width.
- CTRL_W, 4, alu_control width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- instr  in  24  current IR contents from datapath
- alu_z  in  1  ALU zero flag
- alu_n  in  1  ALU negative flag (bit 23)
- alu_cout  in  1  ALU carry out
- pc_write  out  1  PC register load
- ir_write  out  1  IR load
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- reg_write  out  1  register file write
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR
- alu_src_a  out  1  A_in select: 0=PC, 1=reg[rs]
- alu_src_b  out  2  B_in select: 0=reg[rd], 1=const 1, 2=sext(imm12)
- alu_control  out  4  ALU operation code
- pc_src  out  2  PC input select: 0=ALU result, 1=ALUOut, 2=zext(imm12)
- flags  out  3  registered {c,n,z}
- halted  out  1  FSM in HALT
- illegal_op  out  1  sticky illegal-opcode indicator

Behaviour:
- Reset: clock and reset are one clk; reset is synchronous and active-low (rst_n sampled on rising clk edge).
  - rst_n low at an edge: state<=IDLE, flags<=0, illegal_op<=0. This applies in any state, including mid-instruction.
  - In IDLE every output is 0. IDLE always goes to FETCH on the next edge.
- All control outputs are pure functions of state and instr opcode; no outputs are registered except flags, halted and illegal_op.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASS_B=5.
- Opcodes: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, ADDI=6, LW=7, SW=8, BZ=9, BN=A, JMP=B, HALT=F. Codes C/D/E are illegal.
- FETCH: mem_read=1, i_or_d=0, ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1, alu_control=ADD, pc_src=0 (PC<=PC+1). Next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=2, alu_control=ADD (ALUOut<=PC+1+sext(imm), the branch target).
  - R-type/ADDI -> EXEC; LW/SW -> ADDR; BZ/BN -> BRANCH; JMP -> JUMP; HALT -> HALT; NOP -> FETCH.
- EXEC: alu_src_a=1. alu_src_b=0 for R-type, 2 for ADDI. alu_control per opcode (ADDI uses ADD).
  - flags<={alu_cout,alu_n,alu_z} at this edge only. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Next state FETCH.
- ADDR: alu_src_a=1, alu_src_b=2, ADD. Next state MEM_RD for LW, MEM_WR for SW. Flags are not updated.
- MEM_RD: mem_read=1, i_or_d=1. Next state MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Next state FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Next state FETCH.
- BRANCH: pc_src=1. pc_write = (BZ & flags.z) | (BN & flags.n), using flags as registered before this edge. Next state FETCH.
- JUMP: pc_write=1, pc_src=2. Next state FETCH.
- HALT: halted=1, all strobes 0. Remains in HALT until rst_n low.
- Cycle counts, including FETCH:
  - NOP 2
  - BZ/BN/JMP 3
  - R-type/ADDI/SW 4
  - LW 5
- Back-to-back instructions need no idle cycle between them.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE sets illegal_op=1 (sticky until reset) and goes to HALT.
- Undefined: an illegal opcode is executed as NOP, and illegal_op is tied to 0.

Decomposition:
- Shared package mc_pkg holds:
  - opcode constants
  - ALU control codes (also used by the ALU)
  - FSM state encoding, 4-bit binary
  - alu_src_b and pc_src select constants
- One natural sub-module: mc_flag_reg, the 3-bit flag register with write enable and sync active-low clear.

Test Plan:
- Reset then ADD (instr=0x112000): IDLE -> FETCH -> DECODE -> EXEC -> ALU_WB. reg_write=1 exactly in cycle 5 after reset release; alu_control=0 in EXEC.
- SUB with alu_z=1 in EXEC, then BZ (instr=0x900004): flags=3'b001; pc_write=1, pc_src=1 in BRANCH. Repeat with alu_z=0: pc_write stays 0.
- LW (0x700010): mem_read, i_or_d=1 in MEM_RD; mem_to_reg=1, reg_write=1 in MEM_WB; 5 cycles total. SW: mem_write pulse exactly 1 cycle.
- rst_n low during MEM_WR: mem_write=0 in the following cycle; state IDLE, flags=0.
- HALT (0xF00000): halted=1 and held for 20 cycles with no strobes. Release only by rst_n.
- Opcode 0xC: with ILLEGAL_TRAP_EN, illegal_op=1 and halted=1. Without it, returns to FETCH after 2 cycles.
